// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/completion controller: opcodes,
// instruction kinds, controller states and default widths.
package alu_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_REG_ADDR_W = 3;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_SHL  = 3'd4;
    localparam logic [2:0] ALU_SHR  = 3'd5;
    localparam logic [2:0] ALU_XOR  = 3'd6;
    localparam logic [2:0] ALU_ZERO = 3'd7;

    localparam logic [1:0] KIND_RR  = 2'd0;
    localparam logic [1:0] KIND_CMP = 2'd1;
    localparam logic [1:0] KIND_BEQ = 2'd2;
    localparam logic [1:0] KIND_BNE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_WB,
        ST_BR
    } ctrl_state_t;

    // Branches compare by subtraction, so the opcode field is ignored for them.
    function automatic logic [2:0] eff_alu_op(input logic [1:0] kind, input logic [2:0] op);
        return (kind == KIND_BEQ || kind == KIND_BNE) ? ALU_SUB : op;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, ALU, writeback and branch signals of the issue controller.
// master = controller side, slave = instruction source / ALU / register file.
interface alu_issue_ctrl_if #(
    parameter int DATA_W     = alu_pkg::DEF_DATA_W,
    parameter int REG_ADDR_W = alu_pkg::DEF_REG_ADDR_W
);
    logic                  InstValid;
    logic                  InstReady;
    logic [1:0]            InstKind;
    logic [2:0]            InstAluOp;
    logic [DATA_W-1:0]     InstA;
    logic [DATA_W-1:0]     InstB;
    logic [REG_ADDR_W-1:0] InstDest;
    logic [DATA_W-1:0]     InstImm;

    logic [DATA_W-1:0]     AluA;
    logic [DATA_W-1:0]     AluB;
    logic [2:0]            AluOp;
    logic [DATA_W-1:0]     AluOut;
    logic                  AluZero;

    logic                  WbValid;
    logic                  WbReady;
    logic [DATA_W-1:0]     WbData;
    logic [REG_ADDR_W-1:0] WbDest;

    logic                  BrValid;
    logic                  BrTaken;
    logic [DATA_W-1:0]     BrTarget;
    logic                  ZeroFlag;

    modport master (
        input  InstValid, InstKind, InstAluOp, InstA, InstB, InstDest, InstImm,
        output InstReady,
        output AluA, AluB, AluOp,
        input  AluOut, AluZero,
        output WbValid, WbData, WbDest,
        input  WbReady,
        output BrValid, BrTaken, BrTarget, ZeroFlag
    );

    modport slave (
        output InstValid, InstKind, InstAluOp, InstA, InstB, InstDest, InstImm,
        input  InstReady,
        input  AluA, AluB, AluOp,
        output AluOut, AluZero,
        input  WbValid, WbData, WbDest,
        output WbReady,
        input  BrValid, BrTaken, BrTarget, ZeroFlag
    );

endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/completion controller: accepts one instruction, feeds the registered
// ALU, waits out its latency, then writes back or resolves a branch.
//
// state   | meaning
// IDLE    | InstReady high, waiting for an instruction
// ISSUE   | latched operands on the ALU, latency counter loaded
// WAIT    | counting down remaining ALU latency
// CAPTURE | ALU output valid; latch result / Zero and route
// WB      | WbValid held until WbReady
// BR      | one-cycle branch resolution strobe
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int ALU_LATENCY = 1
) (
    input  logic                CLK,
    input  logic                Reset,
    alu_issue_ctrl_if.master    bus
);

    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    ctrl_state_t           state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  rdy_q;
    logic [1:0]            kind_q;
    logic [DATA_W-1:0]     a_q;
    logic [DATA_W-1:0]     b_q;
    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic [DATA_W-1:0]     imm_q;
    logic [DATA_W-1:0]     result_q;
    logic                  zero_q;
    logic                  accept;

    assign accept = bus.InstValid && rdy_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) state_n = ST_ISSUE;
            end
            ST_ISSUE: begin
                cnt_n = CNT_W'(ALU_LATENCY - 1);
                if (ALU_LATENCY > 1) state_n = ST_WAIT;
                else                 state_n = ST_CAPTURE;
            end
            ST_WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_n = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                case (kind_q)
                    KIND_RR:  state_n = (dest_q != '0) ? ST_WB : ST_IDLE;
                    KIND_CMP: state_n = ST_IDLE;
                    default:  state_n = ST_BR;
                endcase
            end
            ST_WB: begin
                if (bus.WbReady) state_n = ST_IDLE;
            end
            ST_BR: begin
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rdy_q    <= 1'b0;
            kind_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            dest_q   <= '0;
            imm_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            // Ready is registered so it stays low for the whole reset window.
            rdy_q <= (state_n == ST_IDLE);
            if (state == ST_IDLE && accept) begin
                kind_q <= bus.InstKind;
                a_q    <= bus.InstA;
                b_q    <= bus.InstB;
                op_q   <= eff_alu_op(bus.InstKind, bus.InstAluOp);
                dest_q <= bus.InstDest;
                imm_q  <= bus.InstImm;
            end
            if (state == ST_CAPTURE) begin
                result_q <= bus.AluOut;
                if (kind_q != KIND_RR) zero_q <= bus.AluZero;
            end
        end
    end

    assign bus.InstReady = rdy_q;
    assign bus.AluA      = a_q;
    assign bus.AluB      = b_q;
    assign bus.AluOp     = op_q;
    assign bus.WbValid   = (state == ST_WB);
    assign bus.WbData    = result_q;
    assign bus.WbDest    = dest_q;
    assign bus.BrValid   = (state == ST_BR);
    assign bus.BrTaken   = (state == ST_BR) && ((kind_q == KIND_BEQ) ? zero_q : !zero_q);
    assign bus.BrTarget  = imm_q;
    assign bus.ZeroFlag  = zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural registered ALU;
// one controller at ALU latency 1 and one at latency 3 share the inputs.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst1 = 1'b1;
    logic        rst3 = 1'b1;
    logic        inst_valid = 1'b0;
    logic [1:0]  inst_kind = '0;
    logic [2:0]  inst_op = '0;
    logic [15:0] inst_a = '0;
    logic [15:0] inst_b = '0;
    logic [2:0]  inst_dest = '0;
    logic [15:0] inst_imm = '0;
    logic        wb_ready = 1'b1;

    int n_cmp = 0;
    int n_fail = 0;
    int wbv1 = 0, brv1 = 0, wbv3 = 0, brv3 = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DATA_W(16), .REG_ADDR_W(3)) u_if1 ();
    alu_issue_ctrl_if #(.DATA_W(16), .REG_ADDR_W(3)) u_if3 ();

    assign u_if1.InstValid = inst_valid;
    assign u_if1.InstKind  = inst_kind;
    assign u_if1.InstAluOp = inst_op;
    assign u_if1.InstA     = inst_a;
    assign u_if1.InstB     = inst_b;
    assign u_if1.InstDest  = inst_dest;
    assign u_if1.InstImm   = inst_imm;
    assign u_if1.WbReady   = wb_ready;
    assign u_if3.InstValid = inst_valid;
    assign u_if3.InstKind  = inst_kind;
    assign u_if3.InstAluOp = inst_op;
    assign u_if3.InstA     = inst_a;
    assign u_if3.InstB     = inst_b;
    assign u_if3.InstDest  = inst_dest;
    assign u_if3.InstImm   = inst_imm;
    assign u_if3.WbReady   = wb_ready;

    alu_issue_ctrl #(.DATA_W(16), .REG_ADDR_W(3), .ALU_LATENCY(1)) u_dut1 (
        .CLK(clk), .Reset(rst1), .bus(u_if1.master));
    alu_issue_ctrl #(.DATA_W(16), .REG_ADDR_W(3), .ALU_LATENCY(3)) u_dut3 (
        .CLK(clk), .Reset(rst3), .bus(u_if3.master));

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_OR:  return a | b;
            ALU_AND: return a & b;
            ALU_SHL: return a << b[3:0];
            ALU_SHR: return a >> b[3:0];
            ALU_XOR: return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    logic [15:0] s3a, s3b;
    always_ff @(posedge clk) begin
        u_if1.AluOut  <= alu_f(u_if1.AluA, u_if1.AluB, u_if1.AluOp);
        u_if1.AluZero <= (alu_f(u_if1.AluA, u_if1.AluB, u_if1.AluOp) == 16'h0000);
        s3a           <= alu_f(u_if3.AluA, u_if3.AluB, u_if3.AluOp);
        s3b           <= s3a;
        u_if3.AluOut  <= s3b;
        u_if3.AluZero <= (s3b == 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (u_if1.WbValid) wbv1 <= wbv1 + 1;
        if (u_if1.BrValid) brv1 <= brv1 + 1;
        if (u_if3.WbValid) wbv3 <= wbv3 + 1;
        if (u_if3.BrValid) brv3 <= brv3 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] k, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] d, input logic [15:0] imm);
        inst_kind  = k;
        inst_op    = op;
        inst_a     = a;
        inst_b     = b;
        inst_dest  = d;
        inst_imm   = imm;
        inst_valid = 1'b1;
    endtask

    // Returns one cycle after the accepting edge (controller in ISSUE).
    task automatic issue(input int sel, input logic [1:0] k, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic [2:0] d,
                         input logic [15:0] imm);
        int w;
        drive(k, op, a, b, d, imm);
        w = 0;
        while (!(sel == 1 ? u_if3.InstReady : u_if1.InstReady) && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_ready_timeout dut%0d got InstReady=0 for %0d cycles exp 1", sel, w);
        end
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick(); tick();
        n_cmp++;
        if ({u_if1.InstReady, u_if1.WbValid, u_if1.BrValid, u_if1.BrTaken, u_if1.ZeroFlag} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 00000",
                {u_if1.InstReady, u_if1.WbValid, u_if1.BrValid, u_if1.BrTaken, u_if1.ZeroFlag});
        end
        n_cmp++;
        if ({u_if1.AluA, u_if1.AluB, u_if1.AluOp, u_if1.WbData, u_if1.WbDest, u_if1.BrTarget} !== '0) begin
            n_fail++;
            $display("FAIL reset_buses got A=%h B=%h Op=%0d Wb=%h/%0d Tgt=%h exp all 0",
                u_if1.AluA, u_if1.AluB, u_if1.AluOp, u_if1.WbData, u_if1.WbDest, u_if1.BrTarget);
        end
        rst1 = 1'b0;
        n_cmp++;
        if (u_if1.InstReady !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_early got %b exp 0", u_if1.InstReady);
        end
        tick();
        n_cmp++;
        if (u_if1.InstReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_rise got %b exp 1", u_if1.InstReady);
        end
    endtask

    task automatic test_add();
        issue(0, KIND_RR, ALU_ADD, 16'h0003, 16'h0004, 3'd5, 16'h0000);
        n_cmp++;
        if ({u_if1.AluA, u_if1.AluB, u_if1.AluOp, u_if1.InstReady} !== {16'h0003, 16'h0004, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_issue got A=%h B=%h Op=%0d Rdy=%b exp 0003 0004 0 0",
                u_if1.AluA, u_if1.AluB, u_if1.AluOp, u_if1.InstReady);
        end
        tick();
        n_cmp++;
        if ({u_if1.InstReady, u_if1.WbValid} !== 2'b00) begin
            n_fail++;
            $display("FAIL add_cycle2 got Rdy=%b WbValid=%b exp 0 0", u_if1.InstReady, u_if1.WbValid);
        end
        tick();
        n_cmp++;
        if ({u_if1.WbValid, u_if1.WbData, u_if1.WbDest, u_if1.InstReady} !== {1'b1, 16'h0007, 3'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL add_wb got V=%b D=%h dest=%0d Rdy=%b exp 1 0007 5 0",
                u_if1.WbValid, u_if1.WbData, u_if1.WbDest, u_if1.InstReady);
        end
        tick();
        n_cmp++;
        if ({u_if1.WbValid, u_if1.InstReady} !== 2'b01) begin
            n_fail++;
            $display("FAIL add_after got WbValid=%b Rdy=%b exp 0 1", u_if1.WbValid, u_if1.InstReady);
        end
    endtask

    task automatic test_branch();
        logic [1:0] kinds [2];
        logic       taken [2];
        kinds[0] = KIND_BEQ; taken[0] = 1'b1;
        kinds[1] = KIND_BNE; taken[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            issue(0, kinds[i], ALU_XOR, 16'h1234, 16'h1234, 3'd4, 16'h0040);
            n_cmp++;
            if (u_if1.AluOp !== ALU_SUB) begin
                n_fail++;
                $display("FAIL br%0d_aluop got %0d exp 1", i, u_if1.AluOp);
            end
            tick(); tick();
            n_cmp++;
            if ({u_if1.BrValid, u_if1.BrTaken, u_if1.BrTarget, u_if1.ZeroFlag, u_if1.WbValid}
                    !== {1'b1, taken[i], 16'h0040, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL br%0d_resolve got V=%b T=%b Tgt=%h Z=%b Wb=%b exp 1 %b 0040 1 0", i,
                    u_if1.BrValid, u_if1.BrTaken, u_if1.BrTarget, u_if1.ZeroFlag, u_if1.WbValid, taken[i]);
            end
            tick();
            n_cmp++;
            if ({u_if1.BrValid, u_if1.InstReady} !== 2'b01) begin
                n_fail++;
                $display("FAIL br%0d_after got BrValid=%b Rdy=%b exp 0 1", i, u_if1.BrValid, u_if1.InstReady);
            end
        end
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        issue(0, KIND_RR, ALU_SUB, 16'h0000, 16'h0001, 3'd2, 16'h0000);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({u_if1.WbValid, u_if1.InstReady, u_if1.WbData, u_if1.WbDest} !== {1'b1, 1'b0, 16'hFFFF, 3'd2}) begin
                n_fail++;
                $display("FAIL bp_stall%0d got V=%b Rdy=%b D=%h dest=%0d exp 1 0 ffff 2", i,
                    u_if1.WbValid, u_if1.InstReady, u_if1.WbData, u_if1.WbDest);
            end
            tick();
        end
        wb_ready = 1'b1;
        n_cmp++;
        if ({u_if1.WbValid, u_if1.WbData} !== {1'b1, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL bp_release got V=%b D=%h exp 1 ffff", u_if1.WbValid, u_if1.WbData);
        end
        tick();
        n_cmp++;
        if ({u_if1.WbValid, u_if1.InstReady} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_done got WbValid=%b Rdy=%b exp 0 1", u_if1.WbValid, u_if1.InstReady);
        end
    endtask

    task automatic test_discard_cmp();
        int wb0, br0;
        wb0 = wbv1;
        br0 = brv1;
        issue(0, KIND_RR, ALU_ADD, 16'h0001, 16'h0002, 3'd0, 16'h0000);
        tick(); tick();
        n_cmp++;
        if ({u_if1.WbValid, u_if1.InstReady} !== 2'b01) begin
            n_fail++;
            $display("FAIL r0_discard got WbValid=%b Rdy=%b exp 0 1", u_if1.WbValid, u_if1.InstReady);
        end
        issue(0, KIND_CMP, ALU_SUB, 16'h0005, 16'h0006, 3'd1, 16'h0000);
        tick(); tick();
        n_cmp++;
        if ({u_if1.ZeroFlag, u_if1.InstReady} !== 2'b01) begin
            n_fail++;
            $display("FAIL cmp_ne got Z=%b Rdy=%b exp 0 1", u_if1.ZeroFlag, u_if1.InstReady);
        end
        issue(0, KIND_CMP, ALU_SUB, 16'h0005, 16'h0005, 3'd1, 16'h0000);
        tick(); tick();
        n_cmp++;
        if (u_if1.ZeroFlag !== 1'b1) begin
            n_fail++;
            $display("FAIL cmp_eq got Z=%b exp 1", u_if1.ZeroFlag);
        end
        n_cmp++;
        if (wbv1 - wb0 != 0 || brv1 - br0 != 0) begin
            n_fail++;
            $display("FAIL discard_no_strobe got wb=%0d br=%0d exp 0 0", wbv1 - wb0, brv1 - br0);
        end
    endtask

    task automatic test_lat3_reset();
        int wb0, br0, c;
        rst1 = 1'b1;
        rst3 = 1'b0;
        tick();
        issue(1, KIND_RR, ALU_ADD, 16'h0010, 16'h0020, 3'd1, 16'h0000);
        tick();
        rst3 = 1'b1;
        tick();
        n_cmp++;
        if ({u_if3.InstReady, u_if3.WbValid, u_if3.BrValid, u_if3.BrTaken, u_if3.ZeroFlag} !== 5'b0) begin
            n_fail++;
            $display("FAIL l3_reset_flags got %b exp 00000",
                {u_if3.InstReady, u_if3.WbValid, u_if3.BrValid, u_if3.BrTaken, u_if3.ZeroFlag});
        end
        n_cmp++;
        if ({u_if3.AluA, u_if3.AluB, u_if3.AluOp, u_if3.WbData, u_if3.WbDest, u_if3.BrTarget} !== '0) begin
            n_fail++;
            $display("FAIL l3_reset_buses got A=%h B=%h Op=%0d Wb=%h/%0d exp all 0",
                u_if3.AluA, u_if3.AluB, u_if3.AluOp, u_if3.WbData, u_if3.WbDest);
        end
        wb0 = wbv3;
        br0 = brv3;
        tick();
        rst3 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if (wbv3 != wb0 || brv3 != br0) begin
            n_fail++;
            $display("FAIL l3_abandon got wb=%0d br=%0d exp 0 0", wbv3 - wb0, brv3 - br0);
        end
        issue(1, KIND_RR, ALU_ADD, 16'h0001, 16'h0001, 3'd4, 16'h0000);
        c = 1;
        while (!u_if3.WbValid && c < 20) begin
            tick();
            c++;
        end
        n_cmp++;
        if (c != 5) begin
            n_fail++;
            $display("FAIL l3_latency got %0d cycles exp 5", c);
        end
        n_cmp++;
        if ({u_if3.WbValid, u_if3.WbData, u_if3.WbDest} !== {1'b1, 16'h0002, 3'd4}) begin
            n_fail++;
            $display("FAIL l3_wb got V=%b D=%h dest=%0d exp 1 0002 4",
                u_if3.WbValid, u_if3.WbData, u_if3.WbDest);
        end
        tick();
        rst3 = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops  [4];
        logic [15:0] as   [4];
        logic [15:0] bs   [4];
        logic [2:0]  ds   [4];
        logic [15:0] exps [4];
        int acc, done, cyc, viol;
        logic fire, prev_fire;
        ops[0] = ALU_ADD;  as[0] = 16'h00FF; bs[0] = 16'h0001; ds[0] = 3'd1; exps[0] = 16'h0100;
        ops[1] = ALU_XOR;  as[1] = 16'hF0F0; bs[1] = 16'h0FF0; ds[1] = 3'd6; exps[1] = 16'hFF00;
        ops[2] = ALU_ZERO; as[2] = 16'h1234; bs[2] = 16'h5678; ds[2] = 3'd3; exps[2] = 16'h0000;
        ops[3] = ALU_ADD;  as[3] = 16'hFFFF; bs[3] = 16'h0002; ds[3] = 3'd7; exps[3] = 16'h0001;
        rst1 = 1'b0;
        tick(); tick();
        acc = 0; done = 0; cyc = 0; viol = 0; prev_fire = 1'b0;
        drive(KIND_RR, ops[0], as[0], bs[0], ds[0], 16'h0000);
        while (done < 4 && cyc < 80) begin
            fire = u_if1.InstReady && inst_valid;
            if (prev_fire && u_if1.InstReady) viol++;
            if (u_if1.WbValid && u_if1.InstReady) viol++;
            if (u_if1.WbValid && wb_ready) begin
                n_cmp++;
                if ({u_if1.WbData, u_if1.WbDest} !== {exps[done], ds[done]}) begin
                    n_fail++;
                    $display("FAIL b2b_wb%0d got D=%h dest=%0d exp %h %0d", done,
                        u_if1.WbData, u_if1.WbDest, exps[done], ds[done]);
                end
                done++;
            end
            tick();
            cyc++;
            if (fire) begin
                acc++;
                if (acc < 4) drive(KIND_RR, ops[acc], as[acc], bs[acc], ds[acc], 16'h0000);
                else         inst_valid = 1'b0;
            end
            prev_fire = fire;
        end
        n_cmp++;
        if (done != 4 || acc != 4) begin
            n_fail++;
            $display("FAIL b2b_count got accepts=%0d wbs=%0d exp 4 4", acc, done);
        end
        n_cmp++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL b2b_accept_rule got %0d violations exp 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_backpressure();
        test_discard_cmp();
        test_lat3_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
